// File: rtl/cseladd_serial_ctrl.sv
// Shares one external 4-bit adder slice between two requesters, doing a W-bit add one
// nibble per cycle (LSB first) with the carry chained through a register.
module cseladd_serial_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [4*NIBBLES-1:0] req0_a,
  input  logic [4*NIBBLES-1:0] req0_b,
  input  logic                 req0_cin,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [4*NIBBLES-1:0] req1_a,
  input  logic [4*NIBBLES-1:0] req1_b,
  input  logic                 req1_cin,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_c,
  input  logic [3:0]           add_sum,
  input  logic                 add_carry,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [4*NIBBLES-1:0] res_sum,
  output logic                 res_cout,
  output logic                 res_id,
  output logic                 busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic            last_grant_reg, last_grant_next;
  logic [W-1:0]    a_reg, a_next;
  logic [W-1:0]    b_reg, b_next;
  logic            carry_reg, carry_next;
  logic            id_reg, id_next;
  logic [IW-1:0]   idx_reg, idx_next;
  logic [W-1:0]    sum_reg, sum_next;
  logic            cout_reg, cout_next;
  logic            grant0, grant1;

  logic [3:0]      a_nib [NIBBLES];
  logic [3:0]      b_nib [NIBBLES];

  // Nibble views of the captured operands, and the per-nibble result write-back.
  genvar gi;
  generate
    for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
      assign a_nib[gi] = a_reg[4*gi +: 4];
      assign b_nib[gi] = b_reg[4*gi +: 4];
      assign sum_next[4*gi +: 4] = (state_reg == RUN && idx_reg == IW'(gi)) ?
                                   add_sum : sum_reg[4*gi +: 4];
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    a_next          = a_reg;
    b_next          = b_reg;
    carry_next      = carry_reg;
    id_next         = id_reg;
    idx_next        = idx_reg;
    cout_next       = cout_reg;
    grant0          = 1'b0;
    grant1          = 1'b0;

    case (state_reg)
      IDLE: begin
        // On a tie the requester that did not win last time gets the slot.
        if (!rst) begin
          grant0 = req0_valid & (~req1_valid | last_grant_reg);
          grant1 = req1_valid & (~req0_valid | ~last_grant_reg);
        end
        if (grant0 || grant1) begin
          a_next          = grant1 ? req1_a : req0_a;
          b_next          = grant1 ? req1_b : req0_b;
          carry_next      = grant1 ? req1_cin : req0_cin;
          id_next         = grant1;
          last_grant_next = grant1;
          idx_next        = '0;
          state_next      = RUN;
        end
      end
      RUN: begin
        carry_next = add_carry;
        idx_next   = idx_reg + IW'(1);
        if (idx_reg == LAST_IDX) begin
          cout_next  = add_carry;
          idx_next   = '0;
          state_next = DONE;
        end
      end
      DONE: begin
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      a_reg          <= '0;
      b_reg          <= '0;
      carry_reg      <= 1'b0;
      id_reg         <= 1'b0;
      idx_reg        <= '0;
      sum_reg        <= '0;
      cout_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      a_reg          <= a_next;
      b_reg          <= b_next;
      carry_reg      <= carry_next;
      id_reg         <= id_next;
      idx_reg        <= idx_next;
      sum_reg        <= sum_next;
      cout_reg       <= cout_next;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign add_a      = (state_reg == RUN) ? a_nib[idx_reg] : 4'd0;
  assign add_b      = (state_reg == RUN) ? b_nib[idx_reg] : 4'd0;
  assign add_c      = (state_reg == RUN) ? carry_reg : 1'b0;
  assign res_valid  = (state_reg == DONE);
  assign res_sum    = sum_reg;
  assign res_cout   = cout_reg;
  assign res_id     = id_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_cseladd_serial_ctrl.sv
// Directed bench for cseladd_serial_ctrl; the bench plays the adder slice and scoreboards
// every accepted operation against a full-width reference add.
module tb_cseladd_serial_ctrl;

  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req0_cin;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_cin;
  logic [W-1:0] req1_a, req1_b;
  logic [3:0]   add_a, add_b, add_sum;
  logic         add_c, add_carry;
  logic         res_valid, res_ready, res_cout, res_id, busy;
  logic [W-1:0] res_sum;
  logic [4:0]   add_full;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [W+1:0] sb_q [$];

  cseladd_serial_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_cin(req1_cin),
    .add_a(add_a), .add_b(add_b), .add_c(add_c), .add_sum(add_sum), .add_carry(add_carry),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_cout(res_cout),
    .res_id(res_id), .busy(busy)
  );

  // External adder slice
  assign add_full  = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_c};
  assign add_sum   = add_full[3:0];
  assign add_carry = add_full[4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [W+1:0] ref_add(input logic id, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic cin);
    logic [W:0] full;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    return {id, full};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on accept, pop and compare on result transfer.
  always @(negedge clk) begin
    if (!rst) begin
      if (req0_valid && req0_ready) sb_q.push_back(ref_add(1'b0, req0_a, req0_b, req0_cin));
      if (req1_valid && req1_ready) sb_q.push_back(ref_add(1'b1, req1_a, req1_b, req1_cin));
      if (res_valid && res_ready) begin
        logic [W+1:0] exp_r;
        n_cmp++;
        assert (sb_q.size() != 0) else begin
          n_fail++;
          $error("FAIL sb_unexpected: observed id=%0d sum=%0h cout=%0d expected no result",
                 res_id, res_sum, res_cout);
        end
        if (sb_q.size() != 0) begin
          exp_r = sb_q.pop_front();
          $display("result id=%0d sum=%h cout=%0d (expect id=%0d sum=%h cout=%0d) cycle %0d",
                   res_id, res_sum, res_cout, exp_r[W+1], exp_r[W-1:0], exp_r[W], cyc);
          n_cmp++;
          assert ({res_id, res_cout, res_sum} === exp_r) else begin
            n_fail++;
            $error("FAIL sb_result: observed id=%0d cout=%0d sum=%h expected id=%0d cout=%0d sum=%h",
                   res_id, res_cout, res_sum, exp_r[W+1], exp_r[W], exp_r[W-1:0]);
          end
        end
      end
    end
  end

  initial begin
    int n;
    int prev_cyc;
    rst = 1'b1; res_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;

    // 1. reset state
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_res_valid", res_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_readies", {req0_ready, req1_ready}, 0);
      chk("rst_res", {res_id, res_cout, res_sum}, 0);
      chk("rst_add", {add_c, add_a, add_b}, 0);
    end
    rst = 1'b0;

    // 2. req0 alone, latency check
    tick();
    req0_a = 16'h00FF; req0_b = 16'h0001; req0_cin = 1'b0; req0_valid = 1'b1;
    #1;
    chk("t2_ready0", req0_ready, 1);
    chk("t2_ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk("t2_busy_run", busy, 1);
      chk("t2_no_res_early", res_valid, 0);
      tick();
    end
    #1;
    chk("t2_res_valid_c5", res_valid, 1);
    chk("t2_sum", res_sum, 32'h0100);
    chk("t2_cout_id", {res_cout, res_id}, 0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    #1;
    chk("t2_idle_after", {busy, res_valid}, 0);

    // 3. req1 alone, carry ripples through every nibble
    tick();
    req1_a = 16'hFFFF; req1_b = 16'h0000; req1_cin = 1'b1; req1_valid = 1'b1;
    #1;
    chk("t3_ready1", req1_ready, 1);
    chk("t3_ready0", req0_ready, 0);
    tick();
    req1_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk("t3_add_c", add_c, 1);
      chk("t3_add_a", add_a, 4'hF);
      tick();
    end
    #1;
    chk("t3_res_valid", res_valid, 1);
    chk("t3_sum", res_sum, 0);
    chk("t3_cout_id", {res_cout, res_id}, 2'b11);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // 4. both valid continuously: alternating grants, 6-cycle spacing
    res_ready = 1'b1;
    req0_a = 16'hFFFF; req0_b = 16'hFFFF; req0_cin = 1'b1; req0_valid = 1'b1;
    req1_a = 16'h1234; req1_b = 16'hEDCB; req1_cin = 1'b1; req1_valid = 1'b1;
    #1;
    prev_cyc = 0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!(req0_ready || req1_ready) && n < 20) begin
        tick(); #1; n++;
      end
      chk("t4_grant_timeout", (n < 20), 1);
      chk("t4_one_ready", {req0_ready, req1_ready}, k[0] ? 2'b01 : 2'b10);
      if (k > 0) chk("t4_spacing", cyc - prev_cyc, 6);
      prev_cyc = cyc;
      tick();
      if (k[0]) begin
        req1_a = 16'($urandom); req1_b = 16'($urandom); req1_cin = 1'($urandom);
      end else begin
        req0_a = 16'($urandom); req0_b = 16'($urandom); req0_cin = 1'($urandom);
      end
      #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n = 0;
    while (sb_q.size() != 0 && n < 30) begin
      tick(); n++;
    end
    chk("t4_drain", sb_q.size(), 0);
    res_ready = 1'b0;

    // 5. back-pressure in DONE
    tick();
    req0_a = 16'hABCD; req0_b = 16'h1234; req0_cin = 1'b0; req0_valid = 1'b1;
    #1;
    chk("t5_ready0", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 20) begin
      tick(); n++;
    end
    chk("t5_done_timeout", (n < 20), 1);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    for (int c = 0; c < 10; c++) begin
      chk("t5_hold_valid_busy", {res_valid, busy}, 2'b11);
      chk("t5_no_ready", {req0_ready, req1_ready}, 0);
      chk("t5_hold_data", {res_id, res_cout, res_sum}, {2'b00, 16'hBE01});
      tick(); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    #1;
    chk("t5_idle_after_release", {busy, res_valid}, 0);

    // 6. reset in RUN at idx 2
    tick();
    req0_a = 16'h1111; req0_b = 16'h2222; req0_cin = 1'b0; req0_valid = 1'b1;
    #1;
    chk("t6_ready0", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    #1;
    chk("t6_idx2_operands", {add_c, add_a, add_b}, {1'b0, 4'h1, 4'h2});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_q.delete();
    #1;
    chk("t6_idle_after_rst", {busy, res_valid}, 0);
    chk("t6_add_zero", {add_c, add_a, add_b}, 0);
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("t6_no_res", res_valid, 0);
    end
    req0_a = 16'h0001; req0_b = 16'hFFFF; req0_cin = 1'b0; req0_valid = 1'b1;
    req1_a = 16'h0F0F; req1_b = 16'h00F1; req1_cin = 1'b1; req1_valid = 1'b1;
    res_ready = 1'b1;
    #1;
    chk("t6_tie_grants_req0", {req0_ready, req1_ready}, 2'b10);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      tick(); n++;
    end
    chk("t6_drain", sb_q.size(), 0);
    res_ready = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
